fft_twiddle_mul: RTL

- Stage directly downstream of the radix-2 butterfly. Consumes NUM_PAIR parallel lanes of butterfly results per beat.
- Sum-half beats pass through unchanged.
- Diff-half beats are multiplied by the current twiddle factor, then rounded and saturated back to WIDTH bits.
- Generates the twiddle ROM address (one twiddle set per diff beat). Fixed 2-cycle latency, full throughput.

---
 rtl/fft_twiddle_mul_if.sv | 34 +++
 rtl/fft_twiddle_mul.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fft_twiddle_mul_if.sv
// Lane bus between the radix-2 butterfly, the twiddle multiplier and its twiddle ROM.
// The master side feeds beats and ROM data; the slave side is the multiplier.
interface fft_twiddle_mul_if #(
    parameter int WIDTH    = 13,
    parameter int TW_WIDTH = 9,
    parameter int NUM_PAIR = 16,
    parameter int NUM_BLK  = 4
);
    localparam int AW = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;

    logic                       frame_start;
    logic                       din_valid;
    logic                       din_diff;
    logic signed [WIDTH-1:0]    din_re [NUM_PAIR];
    logic signed [WIDTH-1:0]    din_im [NUM_PAIR];
    logic [AW-1:0]              tw_addr;
    logic signed [TW_WIDTH-1:0] tw_re [NUM_PAIR];
    logic signed [TW_WIDTH-1:0] tw_im [NUM_PAIR];
    logic signed [WIDTH-1:0]    dout_re [NUM_PAIR];
    logic signed [WIDTH-1:0]    dout_im [NUM_PAIR];
    logic                       dout_valid;
    logic                       dout_diff;
    logic                       sat_flag;

    modport master (
        output frame_start, din_valid, din_diff, din_re, din_im, tw_re, tw_im,
        input  tw_addr, dout_re, dout_im, dout_valid, dout_diff, sat_flag
    );

    modport slave (
        input  frame_start, din_valid, din_diff, din_re, din_im, tw_re, tw_im,
        output tw_addr, dout_re, dout_im, dout_valid, dout_diff, sat_flag
    );
endinterface

// File: rtl/fft_twiddle_mul.sv
// Twiddle multiply after the radix-2 butterfly: diff beats are rotated by the current
// twiddle, rounded and saturated; sum beats pass straight through. Two-cycle latency.
module fft_twiddle_mul #(
    parameter int WIDTH    = 13,
    parameter int TW_WIDTH = 9,
    parameter int NUM_PAIR = 16,
    parameter int NUM_BLK  = 4
) (
    input logic              clk,
    input logic              rstn,
    fft_twiddle_mul_if.slave bus
);
    localparam int PW    = WIDTH + TW_WIDTH;
    localparam int SW    = PW + 1;
    localparam int SHIFT = TW_WIDTH - 2;
    localparam int AW    = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;

    localparam logic signed [SW-1:0] HALF = SW'(2 ** (SHIFT - 1));
    localparam logic signed [SW-1:0] MAXV = SW'(2 ** (WIDTH - 1) - 1);
    localparam logic signed [SW-1:0] MINV = SW'(-(2 ** (WIDTH - 1)));
    localparam logic [AW-1:0]        LAST = AW'(NUM_BLK - 1);
    localparam logic [AW-1:0]        NEXT_AFTER_CLEAR = AW'(1 % NUM_BLK);

    function automatic logic signed [SW-1:0] round_shift(input logic signed [SW-1:0] x);
        return (x + HALF) >>> SHIFT;
    endfunction

    function automatic logic clipped(input logic signed [SW-1:0] x);
        return (x > MAXV) || (x < MINV);
    endfunction

    function automatic logic signed [WIDTH-1:0] saturate(input logic signed [SW-1:0] x);
        if (x > MAXV) return WIDTH'(MAXV);
        if (x < MINV) return WIDTH'(MINV);
        return WIDTH'(x);
    endfunction

    logic          diff_beat;
    logic [AW-1:0] idx;

    assign diff_beat   = bus.din_valid & bus.din_diff;
    assign bus.tw_addr = idx;

    // One twiddle set per diff beat; a coinciding diff beat still uses the old address.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx <= '0;
        end else if (bus.frame_start) begin
            idx <= diff_beat ? NEXT_AFTER_CLEAR : '0;
        end else if (diff_beat) begin
            idx <= (idx == LAST) ? '0 : idx + AW'(1);
        end
    end

    // Stage 1: partial products plus raw samples for the pass-through path
    logic                    vld_p1;
    logic                    diff_p1;
    logic signed [WIDTH-1:0] a_p1  [NUM_PAIR];
    logic signed [WIDTH-1:0] b_p1  [NUM_PAIR];
    logic signed [PW-1:0]    ac_p1 [NUM_PAIR];
    logic signed [PW-1:0]    bd_p1 [NUM_PAIR];
    logic signed [PW-1:0]    ad_p1 [NUM_PAIR];
    logic signed [PW-1:0]    bc_p1 [NUM_PAIR];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1  <= 1'b0;
            diff_p1 <= 1'b0;
            for (int l = 0; l < NUM_PAIR; l++) begin
                a_p1[l]  <= '0;
                b_p1[l]  <= '0;
                ac_p1[l] <= '0;
                bd_p1[l] <= '0;
                ad_p1[l] <= '0;
                bc_p1[l] <= '0;
            end
        end else begin
            vld_p1  <= bus.din_valid;
            diff_p1 <= diff_beat;
            for (int l = 0; l < NUM_PAIR; l++) begin
                a_p1[l]  <= bus.din_re[l];
                b_p1[l]  <= bus.din_im[l];
                ac_p1[l] <= PW'(bus.din_re[l]) * PW'(bus.tw_re[l]);
                bd_p1[l] <= PW'(bus.din_im[l]) * PW'(bus.tw_im[l]);
                ad_p1[l] <= PW'(bus.din_re[l]) * PW'(bus.tw_im[l]);
                bc_p1[l] <= PW'(bus.din_im[l]) * PW'(bus.tw_re[l]);
            end
        end
    end

    logic signed [SW-1:0] rnd_re [NUM_PAIR];
    logic signed [SW-1:0] rnd_im [NUM_PAIR];
    logic [NUM_PAIR-1:0]  clip;

    always_comb begin
        clip = '0;
        for (int l = 0; l < NUM_PAIR; l++) begin
            rnd_re[l] = round_shift(SW'(ac_p1[l]) - SW'(bd_p1[l]));
            rnd_im[l] = round_shift(SW'(ad_p1[l]) + SW'(bc_p1[l]));
            clip[l]   = clipped(rnd_re[l]) | clipped(rnd_im[l]);
        end
    end

    // Stage 2: combine, round, saturate; idle cycles drive zeros
    logic                    vld_p2;
    logic                    diff_p2;
    logic                    sat_p2;
    logic signed [WIDTH-1:0] re_p2 [NUM_PAIR];
    logic signed [WIDTH-1:0] im_p2 [NUM_PAIR];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p2  <= 1'b0;
            diff_p2 <= 1'b0;
            sat_p2  <= 1'b0;
            for (int l = 0; l < NUM_PAIR; l++) begin
                re_p2[l] <= '0;
                im_p2[l] <= '0;
            end
        end else begin
            vld_p2  <= vld_p1;
            diff_p2 <= vld_p1 & diff_p1;
            for (int l = 0; l < NUM_PAIR; l++) begin
                if (!vld_p1) begin
                    re_p2[l] <= '0;
                    im_p2[l] <= '0;
                end else if (diff_p1) begin
                    re_p2[l] <= saturate(rnd_re[l]);
                    im_p2[l] <= saturate(rnd_im[l]);
                end else begin
                    re_p2[l] <= a_p1[l];
                    im_p2[l] <= b_p1[l];
                end
            end
            // A clamp on the same edge as a frame_start clear keeps the flag set.
            if (vld_p1 && diff_p1 && (|clip)) begin
                sat_p2 <= 1'b1;
            end else if (bus.frame_start) begin
                sat_p2 <= 1'b0;
            end
        end
    end

    assign bus.dout_valid = vld_p2;
    assign bus.dout_diff  = diff_p2;
    assign bus.sat_flag   = sat_p2;

    for (genvar g = 0; g < NUM_PAIR; g++) begin : g_out
        assign bus.dout_re[g] = re_p2[g];
        assign bus.dout_im[g] = im_p2[g];
    end
endmodule
